// File: rtl/dut_tester_pkg.sv
// rtl/dut_tester_pkg.sv - shared widths, state encoding and saturating counter helper for the capture block
package dut_tester_pkg;
    localparam int PIN_W  = 128;
    localparam int CNT_W  = 16;
    localparam int TIME_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/capture_dbuf.sv
// rtl/capture_dbuf.sv - shadow/active double buffer; transfers during a run are deferred to a cycle boundary
module capture_dbuf
    import dut_tester_pkg::*;
#(
    parameter int W = 2 * PIN_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_transfer,
    input  logic         i_in_run,
    input  logic         i_apply,
    input  logic [W-1:0] i_load_data,
    output logic [W-1:0] o_active
);
    logic [W-1:0] r_shadow;
    logic [W-1:0] r_active;
    logic         r_pending;
    logic         w_req;

    assign w_req    = i_transfer || r_pending;
    assign o_active = r_active;

    // Copy reads r_shadow before any same-clock load lands, so a load+transfer pair moves the old shadow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_load)
                r_shadow <= i_load_data;
            if (!i_in_run || i_apply) begin
                if (w_req) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (i_transfer) begin
                r_pending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/dut_capture.sv
// rtl/dut_capture.sv - tester capture/compare block; define DUT_CAPTURE_SYNC_EN for a 2-flop input synchronizer
module dut_capture
    import dut_tester_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              PERFORM_TEST,
    input  logic [PIN_W-1:0]  BUS128_0,
    input  logic [PIN_W-1:0]  BUS128_1,
    input  logic              EXP_LOAD,
    input  logic              EXP_TRANSFER,
    input  logic [TIME_W-1:0] STROBE_TIME,
    input  logic [TIME_W-1:0] CYCLE_LENGTH,
    input  logic [PIN_W-1:0]  DUT_INPUTS,
    output logic [PIN_W-1:0]  FAIL_PINS,
    output logic [PIN_W-1:0]  CAPTURED,
    output logic [CNT_W-1:0]  FAIL_COUNT,
    output logic [CNT_W-1:0]  FIRST_FAIL_CYCLE,
    output logic [CNT_W-1:0]  CYCLE_COUNT,
    output logic              FAIL,
    output logic              CAPTURE_VALID,
    output logic              BUSY,
    output logic              CFG_ERR
);
    state_t              r_state;
    logic                r_pt_q;
    logic [TIME_W-1:0]   r_cl;
    logic [TIME_W-1:0]   r_st;
    logic [TIME_W-1:0]   r_phase;
    logic [PIN_W-1:0]    r_fail_pins;
    logic [PIN_W-1:0]    r_captured;
    logic [CNT_W-1:0]    r_fail_count;
    logic [CNT_W-1:0]    r_first_fail;
    logic [CNT_W-1:0]    r_cycle_count;
    logic                r_capture_valid;
    logic                r_cfg_err;

    logic                w_in_run;
    logic                w_run_go;
    logic                w_exit;
    logic                w_wrap;
    logic                w_strobe;
    logic [PIN_W-1:0]    w_sample;
    logic [2*PIN_W-1:0]  w_active;
    logic [PIN_W-1:0]    w_mismatch;

`ifdef DUT_CAPTURE_SYNC_EN
    logic [PIN_W-1:0] r_sync1;
    logic [PIN_W-1:0] r_sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= DUT_INPUTS;
            r_sync2 <= r_sync1;
        end
    end
    assign w_sample = r_sync2;
`else
    assign w_sample = DUT_INPUTS;
`endif

    assign w_in_run   = (r_state == RUN);
    assign w_run_go   = w_in_run && PERFORM_TEST;
    assign w_exit     = w_in_run && !PERFORM_TEST;
    assign w_wrap     = w_run_go && (r_phase == r_cl - TIME_W'(1));
    assign w_strobe   = w_run_go && (r_phase == r_st);
    assign w_mismatch = (w_sample ^ w_active[PIN_W-1:0]) & ~w_active[2*PIN_W-1:PIN_W];

    capture_dbuf #(.W(2 * PIN_W)) u_dbuf (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_load      (EXP_LOAD),
        .i_transfer  (EXP_TRANSFER),
        .i_in_run    (w_in_run),
        .i_apply     (w_wrap || w_exit),
        .i_load_data ({BUS128_1, BUS128_0}),
        .o_active    (w_active)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            r_pt_q          <= 1'b0;
            r_cl            <= '0;
            r_st            <= '0;
            r_phase         <= '0;
            r_fail_pins     <= '0;
            r_captured      <= '0;
            r_fail_count    <= '0;
            r_first_fail    <= '0;
            r_cycle_count   <= '0;
            r_capture_valid <= 1'b0;
            r_cfg_err       <= 1'b0;
        end else begin
            r_pt_q          <= PERFORM_TEST;
            r_capture_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (PERFORM_TEST && !r_pt_q)
                        r_state <= ARM;
                end
                ARM: begin
                    r_cl          <= CYCLE_LENGTH;
                    r_st          <= STROBE_TIME;
                    r_phase       <= '0;
                    r_fail_pins   <= '0;
                    r_fail_count  <= '0;
                    r_first_fail  <= '0;
                    r_cycle_count <= '0;
                    if (CYCLE_LENGTH == '0 || STROBE_TIME >= CYCLE_LENGTH) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cfg_err <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (!PERFORM_TEST) begin
                        r_state <= DONE;
                    end else begin
                        r_phase <= w_wrap ? '0 : r_phase + TIME_W'(1);
                        if (w_wrap)
                            r_cycle_count <= sat_inc(r_cycle_count);
                        if (w_strobe) begin
                            r_captured      <= w_sample;
                            r_capture_valid <= 1'b1;
                            r_fail_pins     <= r_fail_pins | w_mismatch;
                            if (|w_mismatch) begin
                                r_fail_count <= sat_inc(r_fail_count);
                                if (r_fail_count == '0)
                                    r_first_fail <= r_cycle_count;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign FAIL_PINS        = r_fail_pins;
    assign CAPTURED         = r_captured;
    assign FAIL_COUNT       = r_fail_count;
    assign FIRST_FAIL_CYCLE = r_first_fail;
    assign CYCLE_COUNT      = r_cycle_count;
    assign FAIL             = |r_fail_pins;
    assign CAPTURE_VALID    = r_capture_valid;
    assign BUSY             = w_in_run;
    assign CFG_ERR          = r_cfg_err;
endmodule

// File: tb/tb_dut_capture.sv
// tb/tb_dut_capture.sv - scoreboard bench for dut_capture
module tb_dut_capture;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         PERFORM_TEST = 1'b0;
    logic [127:0] BUS128_0 = '0;
    logic [127:0] BUS128_1 = '0;
    logic         EXP_LOAD = 1'b0;
    logic         EXP_TRANSFER = 1'b0;
    logic [7:0]   STROBE_TIME = '0;
    logic [7:0]   CYCLE_LENGTH = '0;
    logic [127:0] DUT_INPUTS = '0;
    logic [127:0] FAIL_PINS, CAPTURED;
    logic [15:0]  FAIL_COUNT, FIRST_FAIL_CYCLE, CYCLE_COUNT;
    logic         FAIL, CAPTURE_VALID, BUSY, CFG_ERR;

    dut_capture dut (
        .CLK(CLK), .RST(RST), .PERFORM_TEST(PERFORM_TEST),
        .BUS128_0(BUS128_0), .BUS128_1(BUS128_1),
        .EXP_LOAD(EXP_LOAD), .EXP_TRANSFER(EXP_TRANSFER),
        .STROBE_TIME(STROBE_TIME), .CYCLE_LENGTH(CYCLE_LENGTH),
        .DUT_INPUTS(DUT_INPUTS), .FAIL_PINS(FAIL_PINS), .CAPTURED(CAPTURED),
        .FAIL_COUNT(FAIL_COUNT), .FIRST_FAIL_CYCLE(FIRST_FAIL_CYCLE),
        .CYCLE_COUNT(CYCLE_COUNT), .FAIL(FAIL), .CAPTURE_VALID(CAPTURE_VALID),
        .BUSY(BUSY), .CFG_ERR(CFG_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] cap;
        logic [127:0] pins;
        logic [15:0]  cnt;
        logic [15:0]  first;
        int           gap;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_err = 0;
    int n_pulses = 0;
    int clk_cnt = 0;
    int last_pulse = 0;

    // spec-level model state
    logic [127:0] m_exp = '0, m_mask = '0, m_sh_exp = '0, m_sh_mask = '0;
    logic [127:0] m_pins = '0;
    logic [15:0]  m_cnt = '0, m_first = '0;
    logic         m_pend = 1'b0;
    logic [127:0] in_lo = '0, in_hi = '0;
    int           in_switch = 0;
    int           xfer_cyc = -1, xfer_ph = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        clk_cnt++;
        if (CAPTURE_VALID) begin
            n_pulses++;
            if (sbq.size() == 0) begin
                chk("unexpected_capture_valid", 128'd1, 128'd0);
            end else begin
                e = sbq.pop_front();
                chk("captured", CAPTURED, e.cap);
                chk("fail_pins", FAIL_PINS, e.pins);
                chk("fail_count", 128'(FAIL_COUNT), 128'(e.cnt));
                chk("first_fail_cycle", 128'(FIRST_FAIL_CYCLE), 128'(e.first));
                chk("fail_flag", 128'(FAIL), 128'(e.pins != 0));
                if (e.gap != 0)
                    chk("pulse_gap", 128'(clk_cnt - last_pulse), 128'(e.gap));
            end
            last_pulse = clk_cnt;
        end
    end

    task automatic load_xfer(input logic [127:0] ex, input logic [127:0] mk, input logic do_load, input logic do_xfer);
        BUS128_0 = ex;
        BUS128_1 = mk;
        EXP_LOAD = do_load;
        EXP_TRANSFER = do_xfer;
        @(negedge CLK);
        EXP_LOAD = 1'b0;
        EXP_TRANSFER = 1'b0;
        if (do_xfer) begin
            m_exp = m_sh_exp;
            m_mask = m_sh_mask;
        end
        if (do_load) begin
            m_sh_exp = ex;
            m_sh_mask = mk;
        end
    endtask

    task automatic start_test(input int cl, input int st);
        CYCLE_LENGTH = 8'(cl);
        STROBE_TIME = 8'(st);
        PERFORM_TEST = 1'b1;
        m_pins = '0;
        m_cnt = '0;
        m_first = '0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic stop_test();
        PERFORM_TEST = 1'b0;
        @(negedge CLK);
        if (m_pend) begin
            m_exp = m_sh_exp;
            m_mask = m_sh_mask;
            m_pend = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic run_cycles(input int n, input int cl, input int st);
        logic [127:0] mism;
        exp_t e;
        bit first_strobe = 1'b1;
        for (int c = 0; c < n; c++) begin
            DUT_INPUTS = (c >= in_switch) ? in_hi : in_lo;
            for (int p = 0; p < cl; p++) begin
                EXP_TRANSFER = (c == xfer_cyc && p == xfer_ph);
                if (p == st) begin
                    mism = (DUT_INPUTS ^ m_exp) & ~m_mask;
                    m_pins |= mism;
                    if (mism != 0) begin
                        if (m_cnt == 0) m_first = 16'(c);
                        m_cnt++;
                    end
                    e.cap = DUT_INPUTS;
                    e.pins = m_pins;
                    e.cnt = m_cnt;
                    e.first = m_first;
                    e.gap = first_strobe ? 0 : cl;
                    first_strobe = 1'b0;
                    sbq.push_back(e);
                end
                if (EXP_TRANSFER) m_pend = 1'b1;
                @(negedge CLK);
                if (p == cl - 1 && m_pend) begin
                    m_exp = m_sh_exp;
                    m_mask = m_sh_mask;
                    m_pend = 1'b0;
                end
            end
        end
        EXP_TRANSFER = 1'b0;
    endtask

    task automatic set_inputs(input logic [127:0] lo, input logic [127:0] hi, input int sw);
        in_lo = lo;
        in_hi = hi;
        in_switch = sw;
        DUT_INPUTS = lo;
    endtask

    initial begin
        int p0;
        logic [127:0] pat_a;
        pat_a = {32{4'hA}};
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_fail_pins", FAIL_PINS, 0);
        chk("rst_captured", CAPTURED, 0);
        chk("rst_fail_count", 128'(FAIL_COUNT), 0);
        chk("rst_first_fail", 128'(FIRST_FAIL_CYCLE), 0);
        chk("rst_cycle_count", 128'(CYCLE_COUNT), 0);
        chk("rst_flags", {FAIL, CAPTURE_VALID, BUSY, CFG_ERR}, 0);

        // all-zero pass run, 80-clock cycles
        load_xfer(0, 0, 1, 0);
        load_xfer(0, 0, 0, 1);
        set_inputs(0, 0, 0);
        p0 = n_pulses;
        start_test(80, 60);
        chk("run_busy", 128'(BUSY), 1);
        run_cycles(10, 80, 60);
        stop_test();
        chk("t1_fail", 128'(FAIL), 0);
        chk("t1_cycle_count", 128'(CYCLE_COUNT), 10);
        chk("t1_pulses", 128'(n_pulses - p0), 10);
        chk("t1_busy_done", 128'(BUSY), 0);

        // single pin fails from cycle 3
        set_inputs(0, 128'h1, 3);
        start_test(8, 4);
        run_cycles(6, 8, 4);
        stop_test();
        chk("t2_fail_pins", FAIL_PINS, 128'h1);
        chk("t2_first_fail", 128'(FIRST_FAIL_CYCLE), 3);
        chk("t2_fail_count", 128'(FAIL_COUNT), 3);
        chk("t2_cycle_count", 128'(CYCLE_COUNT), 6);

        // masked pattern; load+transfer in one clock moves the old shadow
        set_inputs(pat_a, pat_a, 0);
        load_xfer(0, pat_a, 1, 0);
        load_xfer(0, 0, 1, 1);
        start_test(4, 2);
        run_cycles(3, 4, 2);
        stop_test();
        chk("t3_masked_fail", 128'(FAIL), 0);
        chk("t3_captured", CAPTURED, pat_a);
        load_xfer(0, 0, 0, 1);
        start_test(4, 2);
        run_cycles(3, 4, 2);
        stop_test();
        chk("t3_unmasked_pins", FAIL_PINS, pat_a);
        chk("t3_unmasked_count", 128'(FAIL_COUNT), 3);

        // transfer at phase 30 of cycle 5 takes effect from cycle 6
        set_inputs(0, 0, 0);
        load_xfer(128'hF0, 0, 1, 0);
        xfer_cyc = 5;
        xfer_ph = 30;
        start_test(40, 35);
        run_cycles(8, 40, 35);
        xfer_cyc = -1;
        stop_test();
        chk("t4_first_fail", 128'(FIRST_FAIL_CYCLE), 6);
        chk("t4_fail_count", 128'(FAIL_COUNT), 2);
        chk("t4_fail_pins", FAIL_PINS, 128'hF0);

        // invalid timing goes straight to DONE with no strobes
        for (int k = 0; k < 2; k++) begin
            p0 = n_pulses;
            start_test(k == 0 ? 80 : 0, k == 0 ? 80 : 0);
            chk("cfg_err", 128'(CFG_ERR), 1);
            chk("cfg_err_busy", 128'(BUSY), 0);
            repeat (5) @(negedge CLK);
            stop_test();
            chk("cfg_err_pulses", 128'(n_pulses - p0), 0);
        end

        // one-clock cycle strobes every clock
        load_xfer(128'h5, 0, 1, 0);
        load_xfer(128'h5, 0, 0, 1);
        set_inputs(128'h5, 128'h5, 0);
        repeat (3) @(negedge CLK);
        start_test(1, 0);
        chk("t6_cfg_err_clear", 128'(CFG_ERR), 0);
        run_cycles(5, 1, 0);
        stop_test();
        chk("t6_cycle_count", 128'(CYCLE_COUNT), 5);
        chk("t6_fail_count", 128'(FAIL_COUNT), 0);
        chk("t6_captured", CAPTURED, 128'h5);

        // reset during a strobe clock abandons the run
        set_inputs(128'h3, 128'h3, 0);
        start_test(8, 4);
        run_cycles(2, 8, 4);
        repeat (4) @(negedge CLK);
        chk("t7_pre_rst_fail", 128'(FAIL), 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t7_rst_valid", 128'(CAPTURE_VALID), 0);
        chk("t7_rst_flags", {FAIL, BUSY, CFG_ERR}, 0);
        chk("t7_rst_pins", FAIL_PINS, 0);
        chk("t7_rst_captured", CAPTURED, 0);
        chk("t7_rst_counts", {FAIL_COUNT, FIRST_FAIL_CYCLE, CYCLE_COUNT}, 0);
        RST = 1'b0;
        PERFORM_TEST = 1'b0;
        m_exp = '0; m_mask = '0; m_sh_exp = '0; m_sh_mask = '0; m_pend = 1'b0;
        set_inputs(0, 0, 0);
        repeat (2) @(negedge CLK);
        start_test(8, 4);
        run_cycles(2, 8, 4);
        stop_test();
        chk("t7_rerun_cycles", 128'(CYCLE_COUNT), 2);
        chk("t7_rerun_fail", 128'(FAIL), 0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", 128'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
